// File: rtl/icw_ocw_sequencer.sv
// 8259 command-write sequencer: decodes CPU writes into ICW1..4 / OCW1..3,
// tracks the init sequence and latches configuration fields.
module icw_ocw_sequencer #(
  parameter bit         IMR_CLEAR_ON_ICW1 = 1'b1,
  parameter logic [7:0] RESET_MASK        = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic       address_a0,
  input  logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1_reset,
  output logic       write_initial_command_word_2_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic [7:0] command_data,
  output logic [1:0] icw_stage,
  output logic       init_done,
  output logic       level_or_edge_triggered_config,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       u8086_or_mcs80_config,
  output logic       auto_eoi_config,
  output logic       buffered_master_or_slave,
  output logic       buffered_mode_config,
  output logic       special_fully_nest_config,
  output logic [7:0] interrupt_mask
);

  typedef enum logic [2:0] {
    StUninit,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } state_e;

  state_e      state_q, state_d;
  logic        icw1_q, icw1_d;
  logic        icw24_q, icw24_d;
  logic        ocw1_q, ocw1_d;
  logic        ocw2_q, ocw2_d;
  logic        ocw3_q, ocw3_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        ltim_q, ltim_d;
  logic        sngl_q, sngl_d;
  logic        ic4_q, ic4_d;
  logic [4:0]  vbase_q, vbase_d;
  logic [7:0]  cascade_q, cascade_d;
  logic [4:0]  icw4_q, icw4_d;
  logic [7:0]  mask_q, mask_d;

  logic is_icw1, is_ocw2, is_ocw3;

  assign is_icw1 = !address_a0 && internal_data_bus[4];
  assign is_ocw2 = !address_a0 && !internal_data_bus[4] && !internal_data_bus[3];
  assign is_ocw3 = !address_a0 && !internal_data_bus[4] && internal_data_bus[3];

  always_comb begin
    state_d   = state_q;
    icw1_d    = 1'b0;
    icw24_d   = 1'b0;
    ocw1_d    = 1'b0;
    ocw2_d    = 1'b0;
    ocw3_d    = 1'b0;
    cmd_d     = cmd_q;
    ltim_d    = ltim_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    vbase_d   = vbase_q;
    cascade_d = cascade_q;
    icw4_d    = icw4_q;
    mask_d    = mask_q;

    if (write_strobe) begin
      if (is_icw1) begin
        // ICW1 restarts initialization from any state.
        icw1_d    = 1'b1;
        cmd_d     = internal_data_bus;
        ltim_d    = internal_data_bus[3];
        sngl_d    = internal_data_bus[1];
        ic4_d     = internal_data_bus[0];
        cascade_d = 8'h00;
        icw4_d    = 5'h00;
        if (IMR_CLEAR_ON_ICW1) mask_d = 8'h00;
        state_d   = StWaitIcw2;
      end else begin
        unique case (state_q)
          StWaitIcw2: begin
            if (address_a0) begin
              icw24_d = 1'b1;
              cmd_d   = internal_data_bus;
              vbase_d = internal_data_bus[7:3];
              if (!sngl_q)    state_d = StWaitIcw3;
              else if (ic4_q) state_d = StWaitIcw4;
              else            state_d = StReady;
            end
          end
          StWaitIcw3: begin
            if (address_a0) begin
              icw24_d   = 1'b1;
              cmd_d     = internal_data_bus;
              cascade_d = internal_data_bus;
              state_d   = ic4_q ? StWaitIcw4 : StReady;
            end
          end
          StWaitIcw4: begin
            if (address_a0) begin
              icw24_d = 1'b1;
              cmd_d   = internal_data_bus;
              icw4_d  = internal_data_bus[4:0];
              state_d = StReady;
            end
          end
          StReady: begin
            if (address_a0) begin
              ocw1_d = 1'b1;
              cmd_d  = internal_data_bus;
              mask_d = internal_data_bus;
            end else if (is_ocw2) begin
              ocw2_d = 1'b1;
              cmd_d  = internal_data_bus;
            end else if (is_ocw3) begin
              ocw3_d = 1'b1;
              cmd_d  = internal_data_bus;
            end
          end
          default: ;  // StUninit ignores everything but ICW1
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StUninit;
      icw1_q    <= 1'b0;
      icw24_q   <= 1'b0;
      ocw1_q    <= 1'b0;
      ocw2_q    <= 1'b0;
      ocw3_q    <= 1'b0;
      cmd_q     <= 8'h00;
      ltim_q    <= 1'b0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      vbase_q   <= 5'h00;
      cascade_q <= 8'h00;
      icw4_q    <= 5'h00;
      mask_q    <= RESET_MASK;
    end else begin
      state_q   <= state_d;
      icw1_q    <= icw1_d;
      icw24_q   <= icw24_d;
      ocw1_q    <= ocw1_d;
      ocw2_q    <= ocw2_d;
      ocw3_q    <= ocw3_d;
      cmd_q     <= cmd_d;
      ltim_q    <= ltim_d;
      sngl_q    <= sngl_d;
      ic4_q     <= ic4_d;
      vbase_q   <= vbase_d;
      cascade_q <= cascade_d;
      icw4_q    <= icw4_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    icw_stage = 2'd3;
    unique case (state_q)
      StWaitIcw2: icw_stage = 2'd0;
      StWaitIcw3: icw_stage = 2'd1;
      StWaitIcw4: icw_stage = 2'd2;
      default:    icw_stage = 2'd3;
    endcase
  end

  assign init_done                          = (state_q == StReady);
  assign write_initial_command_word_1_reset = icw1_q;
  assign write_initial_command_word_2_4     = icw24_q;
  assign write_operation_control_word_1     = ocw1_q;
  assign write_operation_control_word_2     = ocw2_q;
  assign write_operation_control_word_3     = ocw3_q;
  assign command_data                       = cmd_q;
  assign level_or_edge_triggered_config     = ltim_q;
  assign single_mode                        = sngl_q;
  assign vector_base                        = vbase_q;
  assign cascade_config                     = cascade_q;
  assign u8086_or_mcs80_config              = icw4_q[0];
  assign auto_eoi_config                    = icw4_q[1];
  assign buffered_master_or_slave           = icw4_q[2];
  assign buffered_mode_config               = icw4_q[3];
  assign special_fully_nest_config          = icw4_q[4];
  assign interrupt_mask                     = mask_q;

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed self-checking bench for icw_ocw_sequencer.
module tb_icw_ocw_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       write_strobe = 1'b0;
  logic       address_a0 = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       icw1, icw24, ocw1, ocw2, ocw3;
  logic [7:0] command_data, cascade_config, interrupt_mask;
  logic [1:0] icw_stage;
  logic       init_done, ltim, sngl, u8086, aeoi, buf_ms, buf_mode, sfnm;
  logic [4:0] vector_base;
  logic [4:0] pulses;
  logic [4:0] icw4_fields;
  int         checks = 0;
  int         fails = 0;

  assign pulses      = {icw1, icw24, ocw1, ocw2, ocw3};
  assign icw4_fields = {sfnm, buf_mode, buf_ms, aeoi, u8086};

  always #5 clock = ~clock;

  icw_ocw_sequencer dut (
    .clock                              (clock),
    .reset                              (reset),
    .write_strobe                       (write_strobe),
    .address_a0                         (address_a0),
    .internal_data_bus                  (internal_data_bus),
    .write_initial_command_word_1_reset (icw1),
    .write_initial_command_word_2_4     (icw24),
    .write_operation_control_word_1     (ocw1),
    .write_operation_control_word_2     (ocw2),
    .write_operation_control_word_3     (ocw3),
    .command_data                       (command_data),
    .icw_stage                          (icw_stage),
    .init_done                          (init_done),
    .level_or_edge_triggered_config     (ltim),
    .single_mode                        (sngl),
    .vector_base                        (vector_base),
    .cascade_config                     (cascade_config),
    .u8086_or_mcs80_config              (u8086),
    .auto_eoi_config                    (aeoi),
    .buffered_master_or_slave           (buf_ms),
    .buffered_mode_config               (buf_mode),
    .special_fully_nest_config          (sfnm),
    .interrupt_mask                     (interrupt_mask)
  );

  // One strobe; returns #1 after the edge where the registered results appear.
  task automatic do_write(input logic a0, input logic [7:0] data);
    @(posedge clock); #1;
    write_strobe = 1'b1; address_a0 = a0; internal_data_bus = data;
    @(posedge clock); #1;
    write_strobe = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (pulses !== 5'b00000) begin fails++; $display("FAIL reset_pulses: got %b want 00000", pulses); end
    checks++; if (icw_stage !== 2'd3) begin fails++; $display("FAIL reset_stage: got %0d want 3", icw_stage); end
    checks++; if (init_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", init_done); end
    checks++; if (interrupt_mask !== 8'h00) begin fails++; $display("FAIL reset_mask: got %h want 00", interrupt_mask); end
    checks++; if ({command_data, cascade_config, vector_base} !== 21'h0) begin fails++; $display("FAIL reset_fields: got %h want 0", {command_data, cascade_config, vector_base}); end
  endtask

  task automatic test_full_init;
    do_write(1'b0, 8'h19);
    checks++; if (pulses !== 5'b10000) begin fails++; $display("FAIL icw1_pulse: got %b want 10000", pulses); end
    checks++; if (icw_stage !== 2'd0) begin fails++; $display("FAIL icw1_stage: got %0d want 0", icw_stage); end
    checks++; if ({ltim, sngl, command_data} !== {2'b10, 8'h19}) begin fails++; $display("FAIL icw1_fields: got %b %b %h want 1 0 19", ltim, sngl, command_data); end
    do_write(1'b1, 8'hFF);
    checks++; if (pulses !== 5'b01000) begin fails++; $display("FAIL icw2_pulse: got %b want 01000", pulses); end
    checks++; if ({vector_base, icw_stage} !== {5'h1F, 2'd1}) begin fails++; $display("FAIL icw2_vb_stage: got %h %0d want 1f 1", vector_base, icw_stage); end
    do_write(1'b1, 8'h55);
    checks++; if (pulses !== 5'b01000) begin fails++; $display("FAIL icw3_pulse: got %b want 01000", pulses); end
    checks++; if ({cascade_config, icw_stage} !== {8'h55, 2'd2}) begin fails++; $display("FAIL icw3_cas_stage: got %h %0d want 55 2", cascade_config, icw_stage); end
    do_write(1'b1, 8'h00);
    checks++; if (pulses !== 5'b01000) begin fails++; $display("FAIL icw4_pulse: got %b want 01000", pulses); end
    checks++; if ({init_done, icw_stage, icw4_fields} !== {1'b1, 2'd3, 5'h00}) begin fails++; $display("FAIL icw4_ready: got %b %0d %b want 1 3 00000", init_done, icw_stage, icw4_fields); end
    @(posedge clock); #1;
    checks++; if (pulses !== 5'b00000) begin fails++; $display("FAIL pulse_width: got %b want 00000", pulses); end
  endtask

  task automatic test_ocw1_reinit;
    do_write(1'b1, 8'h07);
    checks++; if (pulses !== 5'b00100) begin fails++; $display("FAIL ocw1_pulse: got %b want 00100", pulses); end
    checks++; if ({interrupt_mask, command_data} !== 16'h0707) begin fails++; $display("FAIL ocw1_mask: got %h %h want 07 07", interrupt_mask, command_data); end
    do_write(1'b0, 8'h13);
    checks++; if (pulses !== 5'b10000) begin fails++; $display("FAIL reinit_pulse: got %b want 10000", pulses); end
    checks++; if ({interrupt_mask, init_done, icw_stage} !== {8'h00, 1'b0, 2'd0}) begin fails++; $display("FAIL reinit_state: got %h %b %0d want 00 0 0", interrupt_mask, init_done, icw_stage); end
    checks++; if ({cascade_config, sngl, ltim} !== {8'h00, 2'b10}) begin fails++; $display("FAIL reinit_fields: got %h %b %b want 00 1 0", cascade_config, sngl, ltim); end
    do_write(1'b1, 8'h20);
    checks++; if ({pulses, icw_stage} !== {5'b01000, 2'd2}) begin fails++; $display("FAIL sngl_skip_icw3: got %b %0d want 01000 2", pulses, icw_stage); end
    do_write(1'b1, 8'hF5);
    checks++; if ({icw4_fields, init_done} !== {5'b10101, 1'b1}) begin fails++; $display("FAIL icw4_fields: got %b %b want 10101 1", icw4_fields, init_done); end
  endtask

  task automatic test_single_no_icw4;
    do_write(1'b0, 8'h12);
    checks++; if (icw4_fields !== 5'b00000) begin fails++; $display("FAIL icw1_clears_icw4: got %b want 00000", icw4_fields); end
    do_write(1'b1, 8'h40);
    checks++; if (pulses !== 5'b01000) begin fails++; $display("FAIL direct_icw2_pulse: got %b want 01000", pulses); end
    checks++; if ({vector_base, init_done, icw_stage, cascade_config} !== {5'h08, 1'b1, 2'd3, 8'h00}) begin fails++; $display("FAIL direct_ready: got %h %b %0d %h want 08 1 3 00", vector_base, init_done, icw_stage, cascade_config); end
    do_write(1'b1, 8'h5A);
    checks++; if ({pulses, interrupt_mask} !== {5'b00100, 8'h5A}) begin fails++; $display("FAIL post_ready_ocw1: got %b %h want 00100 5a", pulses, interrupt_mask); end
  endtask

  task automatic test_ignored_ocw;
    do_write(1'b0, 8'h11);
    do_write(1'b1, 8'h08);
    do_write(1'b0, 8'h20);
    checks++; if ({pulses, icw_stage} !== {5'b00000, 2'd1}) begin fails++; $display("FAIL ocw2_in_wait: got %b %0d want 00000 1", pulses, icw_stage); end
    do_write(1'b0, 8'h0A);
    checks++; if ({pulses, icw_stage} !== {5'b00000, 2'd1}) begin fails++; $display("FAIL ocw3_in_wait: got %b %0d want 00000 1", pulses, icw_stage); end
    do_write(1'b1, 8'h04);
    do_write(1'b1, 8'h01);
    do_write(1'b0, 8'h20);
    checks++; if ({pulses, command_data} !== {5'b00010, 8'h20}) begin fails++; $display("FAIL ocw2_ready: got %b %h want 00010 20", pulses, command_data); end
    do_write(1'b0, 8'h0A);
    checks++; if ({pulses, command_data, icw_stage} !== {5'b00001, 8'h0A, 2'd3}) begin fails++; $display("FAIL ocw3_ready: got %b %h %0d want 00001 0a 3", pulses, command_data, icw_stage); end
  endtask

  task automatic test_restart;
    do_write(1'b0, 8'h11);
    do_write(1'b1, 8'h08);
    do_write(1'b0, 8'h13);
    checks++; if ({pulses, icw_stage} !== {5'b10000, 2'd0}) begin fails++; $display("FAIL restart: got %b %0d want 10000 0", pulses, icw_stage); end
    do_write(1'b1, 8'h10);
    checks++; if ({pulses, vector_base, icw_stage} !== {5'b01000, 5'h02, 2'd2}) begin fails++; $display("FAIL restart_icw2: got %b %h %0d want 01000 02 2", pulses, vector_base, icw_stage); end
  endtask

  task automatic test_back_to_back;
    @(posedge clock); #1;
    write_strobe = 1'b1; address_a0 = 1'b1; internal_data_bus = 8'h1F;
    @(posedge clock); #1;
    address_a0 = 1'b1; internal_data_bus = 8'h3C;
    checks++; if ({pulses, icw4_fields} !== {5'b01000, 5'b11111}) begin fails++; $display("FAIL b2b_icw4: got %b %b want 01000 11111", pulses, icw4_fields); end
    @(posedge clock); #1;
    address_a0 = 1'b0; internal_data_bus = 8'h0A;
    checks++; if ({pulses, interrupt_mask} !== {5'b00100, 8'h3C}) begin fails++; $display("FAIL b2b_ocw1: got %b %h want 00100 3c", pulses, interrupt_mask); end
    @(posedge clock); #1;
    write_strobe = 1'b0;
    checks++; if ({pulses, command_data} !== {5'b00001, 8'h0A}) begin fails++; $display("FAIL b2b_ocw3: got %b %h want 00001 0a", pulses, command_data); end
    @(posedge clock); #1;
    checks++; if (pulses !== 5'b00000) begin fails++; $display("FAIL b2b_idle: got %b want 00000", pulses); end
  endtask

  task automatic test_reset_with_strobe;
    @(posedge clock); #1;
    reset = 1'b1; write_strobe = 1'b1; address_a0 = 1'b1; internal_data_bus = 8'hAA;
    @(posedge clock); #1;
    reset = 1'b0; write_strobe = 1'b0;
    checks++; if ({pulses, interrupt_mask} !== {5'b00000, 8'h00}) begin fails++; $display("FAIL reset_wins: got %b %h want 00000 00", pulses, interrupt_mask); end
    checks++; if ({init_done, icw_stage} !== {1'b0, 2'd3}) begin fails++; $display("FAIL reset_wins_state: got %b %0d want 0 3", init_done, icw_stage); end
    do_write(1'b1, 8'h77);
    checks++; if ({pulses, interrupt_mask, icw_stage} !== {5'b00000, 8'h00, 2'd3}) begin fails++; $display("FAIL uninit_a0_ignored: got %b %h %0d want 00000 00 3", pulses, interrupt_mask, icw_stage); end
    do_write(1'b0, 8'h20);
    checks++; if ({pulses, command_data} !== {5'b00000, 8'h00}) begin fails++; $display("FAIL uninit_ocw2_ignored: got %b %h want 00000 00", pulses, command_data); end
  endtask

  initial begin
    test_reset();
    test_full_init();
    test_ocw1_reinit();
    test_single_no_icw4();
    test_ignored_ocw();
    test_restart();
    test_back_to_back();
    test_reset_with_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/icw_ocw_sequencer.md
Name: icw_ocw_sequencer

Overview:
- Command-write sequencer for the 8259 PIC. Sits between bus control logic and the controller.
- Classifies each CPU write (A0 + data) as ICW1..ICW4 or OCW1..OCW3 and tracks the initialization sequence in an FSM.
- Latches the configuration fields.
- Issues the single-cycle write pulses the controller consumes: write_initial_command_word_1_reset, write_initial_command_word_2_4, write_operation_control_word_1/2/3.

Parameters:
- IMR_CLEAR_ON_ICW1, 1, 1 = an ICW1 write clears interrupt_mask to 8'h00; 0 = mask retained.
- RESET_MASK, 8'h00, interrupt_mask value applied at reset.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- write_strobe  input  1  one-cycle pulse per CPU write, from bus control.
- address_a0  input  1  A0 of the write.
- internal_data_bus  input  8  write data, valid when write_strobe=1.
- write_initial_command_word_1_reset  output  1  one-cycle pulse: ICW1 accepted.
- write_initial_command_word_2_4  output  1  one-cycle pulse: ICW2, ICW3 or ICW4 accepted.
- write_operation_control_word_1  output  1  one-cycle pulse: OCW1 accepted.
- write_operation_control_word_2  output  1  one-cycle pulse: OCW2 accepted.
- write_operation_control_word_3  output  1  one-cycle pulse: OCW3 accepted.
- command_data  output  8  registered copy of the accepted word; valid with any pulse.
- icw_stage  output  2  0=ICW2 next, 1=ICW3 next, 2=ICW4 next, 3=none pending.
- init_done  output  1  1 when in READY.
- level_or_edge_triggered_config  output  1  ICW1 D3 (LTIM).
- single_mode  output  1  ICW1 D1 (SNGL).
- vector_base  output  5  ICW2 D7:D3.
- cascade_config  output  8  ICW3 byte.
- u8086_or_mcs80_config  output  1  ICW4 D0.
- auto_eoi_config  output  1  ICW4 D1.
- buffered_master_or_slave  output  1  ICW4 D2.
- buffered_mode_config  output  1  ICW4 D3.
- special_fully_nest_config  output  1  ICW4 D4.
- interrupt_mask  output  8  OCW1 mask register.

Behaviour:
- Reset (synchronous): state=UNINIT; all pulses 0; command_data, config fields, cascade_config = 0; interrupt_mask=RESET_MASK; icw_stage=3; init_done=0.
- Classification (write_strobe=1 only):
  - A0=0, D4=1 → ICW1.
  - A0=0, D4=0, D3=0 → OCW2.
  - A0=0, D4=0, D3=1 → OCW3.
  - A0=1 → next ICW if an init is in progress, else OCW1.
- Latency: pulse and command_data are registered, asserted exactly in the cycle after the strobe, for one cycle. Latched fields update in that same cycle.
- FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1, accepted in any state:
  - Latch LTIM and SNGL; store IC4 (D0) internally.
  - Clear the ICW4 fields and cascade_config.
  - Clear interrupt_mask if IMR_CLEAR_ON_ICW1.
  - Go to WAIT_ICW2 (icw_stage=0, init_done=0).
  - An ICW1 mid-sequence restarts the sequence; no other field is kept.
- WAIT_ICW2 with A0=1: latch vector_base; go to WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3 with A0=1: latch cascade_config; go to WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4 with A0=1: latch the five ICW4 fields (D7:D5 ignored); go to READY.
- Every accepted ICW2/3/4 pulses write_initial_command_word_2_4.
- Writes ignored (no pulse, no state change):
  - OCW2/OCW3 writes in WAIT_* states.
  - Any write other than ICW1 in UNINIT.
- READY:
  - A0=1: interrupt_mask ← data, pulse OCW1.
  - OCW2/OCW3 decode: pulse write_operation_control_word_2 or _3 with command_data; no local state change.
- icw_stage encoding: WAIT_ICW2=0, WAIT_ICW3=1, WAIT_ICW4=2, UNINIT/READY=3.
- Back-to-back strobes in consecutive cycles must each be processed; pulses may then be high in consecutive cycles.
- Reset asserted with a strobe: reset wins and the write is discarded.
- At most one pulse output high in any cycle.

Test Plan:
- Reset, then ICW1=8'h19 (SNGL=0, IC4=1, LTIM=1), ICW2=8'hFF, ICW3=8'h55, ICW4=8'h00 → four pulses at strobe+1; vector_base=5'h1F, cascade_config=8'h55, LTIM=1, icw_stage 0→1→2→3, init_done=1 after ICW4.
- After init, A0=1 data 8'h07 → write_operation_control_word_1 pulse, interrupt_mask=8'h07; then ICW1 8'h13 → interrupt_mask=8'h00, init_done=0, icw_stage=0.
- ICW1=8'h12 (SNGL=1, IC4=0), ICW2=8'h40 → READY directly after ICW2; vector_base=5'h08; ICW4 fields=0; cascade_config=0; one write_initial_command_word_2_4 pulse.
- In WAIT_ICW3, write A0=0 8'h20 (OCW2) → no pulse, still WAIT_ICW3. In READY, the same write → write_operation_control_word_2 pulse, command_data=8'h20. In READY, A0=0 8'h0A → write_operation_control_word_3 pulse.
- ICW1 8'h11, ICW2 8'h08, then ICW1 8'h13 mid-sequence → restart to WAIT_ICW2; subsequent A0=1 8'h10 latches vector_base=5'h02.
- Strobe (A0=1, 8'hAA) in READY coincident with reset → interrupt_mask=RESET_MASK, no pulse, state UNINIT. Next write A0=1 in UNINIT → ignored.
